// File: rtl/univ_shift_register_n.sv
// univ_shift_register_n
//   Parametrised universal shift register with a start-triggered burst
//   serializer. When the block is idle, one of eight operations is applied
//   each cycle. A start request loads D and shifts it out LSB-first on sout
//   for WIDTH cycles. busy is high during the burst, and done pulses once
//   after the burst ends.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   mode   : operation select, honoured only when idle and start=0
//   D      : parallel load data (mode load and start)
//   sin_r  : serial input into the MSB on right shifts and burst shifts
//   sin_l  : serial input into the LSB on left shifts
//   start  : burst request, sampled on the clock edge
//   A      : register contents (registered)
//   sout   : serial output, always A[0]
//   busy   : high while a burst is in progress (registered)
//   done   : one-cycle pulse after the last burst shift (registered)
module univ_shift_register_n #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_t;

  state_t           state, state_n;
  mode_t            op;
  logic [WIDTH-1:0] a, a_n;
  logic [CW-1:0]    count, count_n;
  logic             busy_n, done_n;

  assign op = mode_t'(mode);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. While a burst runs, start is dropped rather than queued.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start)         state_n = SHIFT;
      SHIFT: if (count == LAST) state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  // Datapath and status. busy and done are computed one cycle ahead so that
  // both leave the block registered.
  always_comb begin
    a_n     = a;
    count_n = count;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_n     = D;
          count_n = '0;
        end else begin
          unique case (op)
            MODE_HOLD: a_n = a;
            MODE_SHR:  a_n = {sin_r, a[WIDTH-1:1]};
            MODE_SHL:  a_n = {a[WIDTH-2:0], sin_l};
            MODE_ROR:  a_n = {a[0], a[WIDTH-1:1]};
            MODE_ROL:  a_n = {a[WIDTH-2:0], a[WIDTH-1]};
            MODE_LOAD: a_n = D;
            MODE_ASR:  a_n = {a[WIDTH-1], a[WIDTH-1:1]};
            MODE_CLR:  a_n = '0;
            default:   a_n = a;
          endcase
        end
      end
      SHIFT: begin
        a_n     = {sin_r, a[WIDTH-1:1]};
        count_n = count + CW'(1);
      end
      default: begin
        a_n     = a;
        count_n = count;
      end
    endcase
    busy_n = (state_n == SHIFT);
    done_n = (state == SHIFT) && (count == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= RESET_VALUE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      a     <= a_n;
      count <= count_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign A    = a;
  assign sout = a[0];

endmodule

// File: tb/tb_univ_shift_register_n.sv
module tb_univ_shift_register_n;

  localparam int unsigned W    = 8;
  localparam logic [W-1:0] RV  = 8'hA5;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic [2:0]   mode;
  logic [W-1:0] D;
  logic         sin_r;
  logic         sin_l;
  logic         start;
  logic [W-1:0] A;
  logic         sout;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_bad;
  int unsigned m_a;   // reference model of A

  univ_shift_register_n #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .mode(mode), .D(D), .sin_r(sin_r), .sin_l(sin_l),
    .start(start), .A(A), .sout(sout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference operation on the register value, written from the mode table.
  function automatic int unsigned model_op(input int unsigned a, input int unsigned m,
                                           input int unsigned d, input int unsigned sr,
                                           input int unsigned sl);
    case (m)
      0: return a;
      1: return (a >> 1) | (sr << (W - 1));
      2: return ((a << 1) | sl) & MASK;
      3: return (a >> 1) | ((a & 1) << (W - 1));
      4: return ((a << 1) & MASK) | (a >> (W - 1));
      5: return d & MASK;
      6: return (a >> 1) | (a & (1 << (W - 1)));
      default: return 0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; mode = 3'd0; D = '0; sin_r = 0; sin_l = 0; start = 0;
    tick(); tick();
    rst = 1'b0;
    mode = 3'd5; D = 8'h3C;
    tick();
    mode = 3'd0;
    n_cmp++;
    if (A !== 8'h3C) begin n_bad++; $display("FAIL reset_preload: A=%h expected %h", A, 8'h3C); end
    // assert reset between edges; outputs must change without a clock edge
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (A !== RV) begin n_bad++; $display("FAIL reset_async_A: A=%h expected %h", A, RV); end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_async_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    #1 rst = 1'b0;
    tick();
    n_cmp++;
    if (A !== RV) begin n_bad++; $display("FAIL reset_hold: A=%h expected %h", A, RV); end
    m_a = RV;
  endtask

  task automatic test_modes_directed();
    logic [2:0]   tm [7];
    logic         tr [7];
    logic         tl [7];
    logic [W-1:0] te [7];
    tm = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0};
    tr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    te = '{8'hCB, 8'h2D, 8'h4B, 8'h2D, 8'hCB, 8'h00, 8'h96};
    for (int i = 0; i < 7; i++) begin
      mode = 3'd5; D = 8'h96; sin_r = 0; sin_l = 0;
      tick();
      mode = tm[i]; sin_r = tr[i]; sin_l = tl[i]; D = 8'h00;
      tick();
      n_cmp++;
      if (A !== te[i]) begin
        n_bad++; $display("FAIL mode_%0d: A=%h expected %h", tm[i], A, te[i]);
      end
    end
    m_a = 8'h96;
    mode = 3'd0;
  endtask

  task automatic test_modes_random();
    int unsigned m, d, sr, sl;
    mode = 3'd5; D = 8'h5E; tick();
    m_a = 8'h5E;
    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 7); d = $urandom_range(0, MASK);
      sr = $urandom_range(0, 1); sl = $urandom_range(0, 1);
      mode = m[2:0]; D = d[W-1:0]; sin_r = sr[0]; sin_l = sl[0];
      tick();
      m_a = model_op(m_a, m, d, sr, sl);
      n_cmp++;
      if (A !== m_a[W-1:0] || sout !== m_a[0] || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_mode_%0d: A=%h sout=%b busy=%b done=%b expected A=%h sout=%b busy=0 done=0",
                 m, A, sout, busy, done, m_a[W-1:0], m_a[0]);
      end
    end
    mode = 3'd0; sin_r = 0; sin_l = 0;
  endtask

  // One burst of D=d; rand_sin drives random sin_r, intrude_k pulses a second
  // start (D=FF) at that busy cycle, or -1 for none.
  task automatic test_burst(input logic [W-1:0] d, input bit rand_sin, input int intrude_k);
    int unsigned sr;
    int dones;
    dones = 0;
    start = 1'b1; D = d; mode = $urandom_range(0, 7);
    tick();
    start = 1'b0;
    m_a = d;
    for (int k = 0; k < W; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || sout !== d[k] || A !== m_a[W-1:0]) begin
        n_bad++;
        $display("FAIL burst_cycle_%0d: busy=%b done=%b sout=%b A=%h expected 1 0 %b %h",
                 k, busy, done, sout, A, d[k], m_a[W-1:0]);
      end
      sr = rand_sin ? $urandom_range(0, 1) : 0;
      sin_r = sr[0]; mode = $urandom_range(0, 7); D = $urandom_range(0, MASK);
      start = (k == intrude_k);
      if (start) D = 8'hFF;
      tick();
      if (done) dones++;
      m_a = model_op(m_a, 1, 0, sr, 0);
    end
    start = 1'b0; mode = 3'd0; sin_r = 0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1 || A !== m_a[W-1:0]) begin
      n_bad++;
      $display("FAIL burst_done: busy=%b done=%b A=%h expected 0 1 %h", busy, done, A, m_a[W-1:0]);
    end
    tick();
    if (done) dones++;
    tick();
    if (done) dones++;
    n_cmp++;
    if (dones !== 1 || busy !== 1'b0 || A !== m_a[W-1:0]) begin
      n_bad++;
      $display("FAIL burst_after: done_pulses=%0d busy=%b A=%h expected 1 0 %h", dones, busy, A, m_a[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1, d2;
    d1 = $urandom_range(0, MASK);
    d2 = 8'h5A;
    start = 1'b1; D = d1; sin_r = 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || sout !== d1[k]) begin
        n_bad++; $display("FAIL b2b_first_%0d: busy=%b sout=%b expected 1 %b", k, busy, sout, d1[k]);
      end
      // hold start from late in the burst through the done cycle
      if (k >= 5) begin start = 1'b1; D = d2; end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done: done=%b busy=%b expected 1 0", done, busy);
    end
    tick();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || sout !== d2[k]) begin
        n_bad++;
        $display("FAIL b2b_second_%0d: busy=%b done=%b sout=%b expected 1 0 %b", k, busy, done, sout, d2[k]);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || A !== '0) begin
      n_bad++; $display("FAIL b2b_second_done: done=%b busy=%b A=%h expected 1 0 00", done, busy, A);
    end
    tick();
    m_a = 0;
  endtask

  task automatic test_reset_mid_burst();
    logic [W-1:0] d;
    int dones;
    dones = 0;
    d = $urandom_range(0, MASK);
    start = 1'b1; D = d; mode = 3'd0; sin_r = 1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || A !== RV) begin
      n_bad++; $display("FAIL midburst_reset: busy=%b done=%b A=%h expected 0 0 %h", busy, done, A, RV);
    end
    #1 rst = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      if (done || busy) dones++;
    end
    n_cmp++;
    if (dones !== 0 || A !== RV) begin
      n_bad++; $display("FAIL midburst_aftermath: done_or_busy_cycles=%0d A=%h expected 0 %h", dones, A, RV);
    end
    sin_r = 0;
    m_a = RV;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_modes_directed();
    test_modes_random();
    test_burst(8'hC3, 1'b0, -1);
    n_cmp++;
    if (A !== 8'h00) begin n_bad++; $display("FAIL burst_c3_final: A=%h expected 00", A); end
    test_burst(8'hC3, 1'b0, 3);
    for (int i = 0; i < 4; i++) test_burst($urandom_range(0, MASK), 1'b1, -1);
    test_back_to_back();
    test_reset_mid_burst();
    test_burst($urandom_range(0, MASK), 1'b1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_register_n.md
Name: univ_shift_register_n

Overview:
- Parametrised N-bit universal shift register; successor to the team's fixed 4-bit load/shift-right register.
- Adds eight operating modes (hold, logical/arithmetic shift, rotate, load, clear) selected per cycle.
- Adds a start-triggered burst serializer that loads a word and shifts it out LSB-first on sout with busy/done status.
- Used as the serial datapath element in the ASIC/FPGA assignment datapaths, e.g. feeding serial links or bit-serial arithmetic.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, 0, value loaded into A on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  3  operation select; honoured only when idle and start=0.
- D  input  WIDTH  parallel load data, used by mode load and by start.
- sin_r  input  1  serial input into the MSB on shift right.
- sin_l  input  1  serial input into the LSB on shift left.
- start  input  1  burst request; sampled on the clk edge.
- A  output  WIDTH  register contents, registered.
- sout  output  1  serial output; combinational, sout = A[0].
- busy  output  1  high while a burst is in progress, registered.
- done  output  1  one-cycle pulse after the last burst shift, registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - rst=1 immediately forces A=RESET_VALUE, busy=0, done=0, state=IDLE, count=0, regardless of clk.
  - Applies mid-burst; the burst is abandoned and no done pulse is produced.
- Mode encoding (IDLE, start=0), applied at the clk edge:
  - 000 hold: A unchanged.
  - 001 shift right: A <= {sin_r, A[WIDTH-1:1]}.
  - 010 shift left: A <= {A[WIDTH-2:0], sin_l}.
  - 011 rotate right: A <= {A[0], A[WIDTH-1:1]}.
  - 100 rotate left: A <= {A[WIDTH-2:0], A[WIDTH-1]}.
  - 101 load: A <= D.
  - 110 arithmetic shift right: A <= {A[WIDTH-1], A[WIDTH-1:1]}.
  - 111 clear: A <= 0. Note this is 0, not RESET_VALUE.
- State machine: two states, IDLE and SHIFT. Internal counter is clog2(WIDTH) bits, derived inside the block.
- IDLE with start=1:
  - start takes priority over mode.
  - At the edge: A <= D, count <= 0, state <= SHIFT, busy <= 1.
- SHIFT, every edge:
  - A <= {sin_r, A[WIDTH-1:1]} and count <= count+1.
  - mode and start are ignored; a start while busy is dropped, not queued.
- SHIFT with count == WIDTH-1:
  - At that edge the final shift still occurs.
  - state <= IDLE, busy <= 0, done <= 1.
- done timing:
  - done is high for exactly one cycle, coinciding with busy=0.
  - done clears on the next edge unconditionally, even if a new start is accepted in that cycle.
- Serial timing:
  - busy is high for exactly WIDTH cycles.
  - In the k-th busy cycle (k = 0..WIDTH-1), sout = D[k], so the word goes out LSB-first.
  - Back-to-back bursts: a start asserted in the done cycle begins a new burst at the next edge, leaving no idle gap beyond the done cycle.
- Boundaries:
  - WIDTH=2 gives a two-cycle burst.
  - Counter wrap is not used; it is reset on each start.
  - A in IDLE after a burst holds the last shifted value; it is not reloaded.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, pulse rst between clk edges -> A=A5, busy=0, done=0 immediately, without waiting for an edge.
- Modes: A=8'b1001_0110.
  - shift right, sin_r=1 -> 1100_1011.
  - shift left, sin_l=1 -> 0010_1101.
  - rotate right -> 0100_1011.
  - rotate left -> 0010_1101.
  - arithmetic shift right on 1001_0110 -> 1100_1011.
  - clear -> 00.
  - hold -> unchanged.
- Burst: D=8'hC3, sin_r=0, one-cycle start -> busy high 8 cycles, sout sequence 1,1,0,0,0,0,1,1, then done=1 for one cycle and A=00.
- Start during burst: second start at busy cycle 3 with D=8'hFF -> ignored, output sequence unchanged, exactly one done.
- Back-to-back: start held high through the done cycle with D=8'h5A -> new burst begins at the next edge, done low again, sout=0,1,0,1,1,0,1,0.
- Reset mid-burst: rst asserted at busy cycle 4 -> busy=0, A=RESET_VALUE at once, no done pulse; a later start operates normally.
